tcdm_burst_reader: RTL and testbench
====================================

Name: tcdm_burst_reader

Overview:
- Synthesizable TCDM initiator. On a start pulse it reads a strided block of 32-bit words over one TCDM master port and delivers the returned data in order on a valid/ready stream.
- Sits between an HWPE controller and the TCDM interconnect. It is the requesting counterpart of our TCDM memory models and is verified against them.
- Credit-limited outstanding requests plus an internal response FIFO keep stream back-pressure lossless.

Parameters:
- DEPTH, 4, response FIFO depth; also the max in-flight-plus-buffered words (power of 2, >=2).
- CNT_W, 16, width of the word counters and of nb_words_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear; same effect as reset
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  32  byte address of word 0; sampled on accepted start
- stride_i  in  32  byte stride between words; sampled on accepted start
- nb_words_i  in  CNT_W  number of words to read; sampled on accepted start
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when the last word leaves the stream
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  32  TCDM byte address
- tcdm_wen_o  out  1  constant 1 (read)
- tcdm_be_o  out  4  constant 4'hF
- tcdm_data_o  out  32  constant 0
- tcdm_r_data_i  in  32  read response data
- tcdm_r_valid_i  in  1  read response valid
- out_data_o  out  32  stream data
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready

Behaviour:
- Reset/clear values: FSM=IDLE; tcdm_req_o=0; tcdm_add_o=0; busy_o=0; done_o=0; out_valid_o=0; out_data_o=0; all counters and the FIFO empty.
- FSM states:
  - IDLE: start_i with nb_words_i>0 → ISSUE. start_i with nb_words_i==0 → DONE with no request issued.
  - ISSUE: after the grant of the last request → DRAIN.
  - DRAIN: when the final word handshakes on the output stream → DONE.
  - DONE: lasts one cycle with done_o=1, then → IDLE.
- start_i outside IDLE is ignored.
- Address generation: request k carries address base + k*stride, mod 2^32 (wrap-around allowed). The address register advances only on req&gnt.
- Request rules:
  - tcdm_req_o is high in ISSUE only when credit = inflight + fifo_count < DEPTH.
  - Once raised, req and add stay stable until gnt, even if credit would fall; credit is reserved when req is raised.
  - A grant in the same cycle as a new request condition allows back-to-back requests, one per cycle.
- Responses: tcdm_r_valid_i arrives exactly one cycle after the gnt cycle, in order. Each r_valid pushes r_data into the FIFO and decrements inflight. The FIFO never overflows by credit construction. An r_valid with inflight==0 is a protocol error: ignored, and flagged by an assertion in simulation.
- Output: out_valid_o = FIFO not empty; out_data_o = FIFO head. A pop happens on valid&ready. Data/valid stay stable while ready is low.
- Simultaneous push and pop: allowed; FIFO count unchanged.
- Full throughput: with ready held high and gnt always 1, one word per cycle. First out_valid_o rises 2 cycles after start_i (1 cycle to request/grant, 1 cycle response).
- Reset or clear mid-burst: the burst is abandoned; responses arriving afterwards are dropped; no done_o.

Optional Feature:
- Macro: TCDM_BURST_READER_PERF_EN.
- Defined: adds output ports stall_cnt_o [31:0] (cycles with req&~gnt) and bp_cnt_o [31:0] (cycles with out_valid&~out_ready). Both zeroed on accepted start, reset and clear; saturating at 2^32-1; hold their value in IDLE.
- Undefined: ports and counters absent.

Decomposition:
- Package tcdm_burst_reader_pkg: FSM state enum (IDLE, ISSUE, DRAIN, DONE) and the constant TCDM_DATA_W=32.
- Sub-module tcdm_burst_reader_fifo: synchronous FIFO with count output, parameterized by DEPTH, with async active-low reset and clear.

Test Plan:
- Basic read: base=0x100, stride=4, nb=8, gnt always 1, ready always 1, memory model holding mem[i]=i → addresses 0x100..0x11C on consecutive cycles; out 0..7 in order; done_o 1 cycle after the last pop; 8 req&gnt total.
- Back-pressure: DEPTH=4, nb=16, ready low for 20 cycles → at most 4 granted before the first pop; no data lost; output sequence correct.
- Grant stalls: gnt with 50% random stalls, stride=12, nb=32 → addr/req stable while gnt=0; 32 words in order; with PERF_EN, stall_cnt_o equals the count of req&~gnt cycles.
- Zero length: nb=0 → no tcdm_req_o; done_o pulses 1 cycle after start; busy_o high for exactly that 1 cycle.
- Wrap and ignored start: base=0xFFFF_FFF8, stride=4, nb=4 → addresses FFF8, FFFC, 0000, 0004; a second start_i during the burst has no effect.
- Clear mid-burst: clear_i after 3 grants of a 10-word burst → outputs return to reset values next cycle; the late r_valid is dropped; a new burst then runs correctly.

Source files
------------

// File: rtl/tcdm_burst_reader_pkg.sv
// tcdm_burst_reader_pkg: shared FSM states and data width for the TCDM burst reader.
package tcdm_burst_reader_pkg;
  localparam int TCDM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
endpackage

// File: rtl/tcdm_burst_reader_fifo.sv
// tcdm_burst_reader_fifo: response FIFO with occupancy count; callers never push when full or pop when empty.
module tcdm_burst_reader_fifo
  import tcdm_burst_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push,
  input  logic [TCDM_DATA_W-1:0] wdata,
  input  logic                   pop,
  output logic [TCDM_DATA_W-1:0] rdata,
  output logic                   empty,
  output logic [AW:0]            count
);
  logic [TCDM_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end
  assign rdata = mem[rptr];
  assign empty = count == '0;
endmodule

// File: rtl/tcdm_burst_reader.sv
// tcdm_burst_reader: strided TCDM block reader streaming words in order under credit flow control.
// Optional TCDM_BURST_READER_PERF_EN adds grant-stall and back-pressure cycle counters.
module tcdm_burst_reader
  import tcdm_burst_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [31:0]            base_addr_i,
  input  logic [31:0]            stride_i,
  input  logic [CNT_W-1:0]       nb_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tcdm_req_o,
  input  logic                   tcdm_gnt_i,
  output logic [31:0]            tcdm_add_o,
  output logic                   tcdm_wen_o,
  output logic [3:0]             tcdm_be_o,
  output logic [TCDM_DATA_W-1:0] tcdm_data_o,
  input  logic [TCDM_DATA_W-1:0] tcdm_r_data_i,
  input  logic                   tcdm_r_valid_i,
  output logic [TCDM_DATA_W-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
`ifdef TCDM_BURST_READER_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            bp_cnt_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state, next;
  logic [31:0] addr;
  logic [CNT_W-1:0] req_left, out_left;
  logic [CW-1:0] inflight, fifo_cnt;
  logic [TCDM_DATA_W-1:0] head;
  logic drop, empty, fire, push, pop, start_ok;
  assign start_ok = state == IDLE && start_i;
  // Credit only grows on a grant, so a raised request cannot lose its credit before being granted.
  assign tcdm_req_o = state == ISSUE && ({1'b0, inflight} + {1'b0, fifo_cnt} < (CW+1)'(DEPTH));
  assign fire = tcdm_req_o && tcdm_gnt_i;
  assign push = tcdm_r_valid_i && inflight != '0;
  assign pop = out_valid_o && out_ready_i;
  assign out_valid_o = !empty;
  assign out_data_o = empty ? '0 : head;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign tcdm_add_o = addr;
  assign tcdm_wen_o = 1'b1;
  assign tcdm_be_o = 4'hF;
  assign tcdm_data_o = '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= clear_i ? IDLE : next;
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = !start_i ? IDLE : nb_words_i == '0 ? DONE : ISSUE;
      ISSUE: next = fire && req_left == CNT_W'(1) ? DRAIN : ISSUE;
      DRAIN: next = pop && out_left == CNT_W'(1) ? DONE : DRAIN;
      DONE:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr     <= '0;
      req_left <= '0;
      out_left <= '0;
      inflight <= '0;
      drop     <= 1'b1;
    end else if (clear_i) begin
      addr     <= '0;
      req_left <= '0;
      out_left <= '0;
      inflight <= '0;
      drop     <= 1'b1;
    end else begin
      drop <= 1'b0;
      if (start_ok) begin
        addr     <= base_addr_i;
        req_left <= nb_words_i;
        out_left <= nb_words_i;
      end else if (fire) begin
        addr     <= addr + stride_i;
        req_left <= req_left - 1'b1;
      end
      if (pop) out_left <= out_left - 1'b1;
      inflight <= inflight + CW'(fire) - CW'(push);
    end
  end
  tcdm_burst_reader_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .push   (push),
    .wdata  (tcdm_r_data_i),
    .pop    (pop),
    .rdata  (head),
    .empty  (empty),
    .count  (fifo_cnt)
  );
  // A response right after reset/clear belongs to an abandoned burst and is legitimately dropped.
  assert property (@(posedge clk_i) disable iff (!rst_ni) tcdm_r_valid_i |-> (inflight != '0 || drop));
`ifdef TCDM_BURST_READER_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      bp_cnt_o    <= '0;
    end else if (clear_i || start_ok) begin
      stall_cnt_o <= '0;
      bp_cnt_o    <= '0;
    end else if (state != IDLE) begin
      if (tcdm_req_o && !tcdm_gnt_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (out_valid_o && !out_ready_i && bp_cnt_o != '1) bp_cnt_o <= bp_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_tcdm_burst_reader.sv
// tb_tcdm_burst_reader: directed bench with a one-cycle-latency TCDM memory model returning (addr-base)>>2.
module tb_tcdm_burst_reader;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic clk_i = 0, rst_ni = 0, clear_i = 0, start_i = 0;
  logic [31:0] base_addr_i = 0, stride_i = 0;
  logic [CNT_W-1:0] nb_words_i = 0;
  logic busy_o, done_o, tcdm_req_o, tcdm_wen_o, out_valid_o;
  logic tcdm_gnt_i = 1, tcdm_r_valid_i = 0, out_ready_i = 1;
  logic [31:0] tcdm_add_o, tcdm_data_o, out_data_o, tcdm_r_data_i = 0;
  logic [3:0] tcdm_be_o;
`ifdef TCDM_BURST_READER_PERF_EN
  logic [31:0] stall_cnt_o, bp_cnt_o;
`endif
  int checks = 0, errors = 0, cyc = 0;
  logic rand_gnt = 0;
  logic [31:0] mbase = 0;
  logic [31:0] addrs[$], pops[$];
  int n_gnt, n_stall, n_bp, n_req, n_busy, n_done, max_out, stab_err;
  int start_cyc, done_cyc, first_valid_cyc, first_gnt_cyc, last_gnt_cyc, first_pop_cyc, last_pop_cyc;
  logic prev_stall, prev_hold;
  logic [31:0] prev_add, hold_data;

  tcdm_burst_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .nb_words_i(nb_words_i),
    .busy_o(busy_o), .done_o(done_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
`ifdef TCDM_BURST_READER_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bp_cnt_o(bp_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  initial forever @(posedge clk_i) cyc++;
  initial forever begin
    @(posedge clk_i);
    tcdm_r_valid_i <= tcdm_req_o && tcdm_gnt_i;
    tcdm_r_data_i <= (tcdm_add_o - mbase) >> 2;
    #1 tcdm_gnt_i = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
  end
  initial forever begin
    @(negedge clk_i);
    if (start_i && !busy_o) start_cyc = cyc;
    if (busy_o) n_busy++;
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (tcdm_req_o) n_req++;
    if (prev_stall && !(tcdm_req_o && tcdm_add_o == prev_add)) stab_err++;
    if (prev_hold && !(out_valid_o && out_data_o == hold_data)) stab_err++;
    prev_stall = tcdm_req_o && !tcdm_gnt_i;
    prev_add = tcdm_add_o;
    prev_hold = out_valid_o && !out_ready_i;
    hold_data = out_data_o;
    if (prev_stall) n_stall++;
    if (prev_hold) n_bp++;
    if (tcdm_req_o && tcdm_gnt_i) begin
      if (n_gnt == 0) first_gnt_cyc = cyc;
      last_gnt_cyc = cyc;
      n_gnt++;
      addrs.push_back(tcdm_add_o);
      if (n_gnt - pops.size() > max_out) max_out = n_gnt - pops.size();
    end
    if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid_o && out_ready_i) begin
      if (pops.size() == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pops.push_back(out_data_o);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic reset_stats();
    addrs.delete(); pops.delete();
    n_gnt = 0; n_stall = 0; n_bp = 0; n_req = 0; n_busy = 0; n_done = 0; max_out = 0; stab_err = 0;
    start_cyc = -1; done_cyc = -1; first_valid_cyc = -1; first_gnt_cyc = -1; last_gnt_cyc = -1;
    first_pop_cyc = -1; last_pop_cyc = -1; prev_stall = 0; prev_hold = 0;
  endtask

  task automatic start_burst(input logic [31:0] b, input logic [31:0] s, input int n);
    @(posedge clk_i); #1;
    base_addr_i = b; stride_i = s; nb_words_i = CNT_W'(n); mbase = b; start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin @(negedge clk_i); seen = done_o; end
    checks++; if (!seen) begin errors++; $display("FAIL done_timeout: done_o not seen within %0d cycles", bound); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    reset_stats();
    @(negedge clk_i);
    checks++; if (tcdm_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", tcdm_req_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", out_valid_o); end
    @(posedge clk_i); #1 rst_ni = 1;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b exp 00", busy_o, done_o); end
    checks++; if (tcdm_add_o !== 32'h0) begin errors++; $display("FAIL rst_add: got %h exp 0", tcdm_add_o); end
    checks++; if (out_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_data_o); end
    checks++; if (tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF || tcdm_data_o !== 32'h0)
      begin errors++; $display("FAIL rst_consts: got wen %b be %h data %h exp 1 f 0", tcdm_wen_o, tcdm_be_o, tcdm_data_o); end
  endtask

  task automatic test_basic();
    reset_stats(); out_ready_i = 1; rand_gnt = 0;
    start_burst(32'h100, 4, 8);
    wait_done(100);
    checks++; if (n_gnt != 8) begin errors++; $display("FAIL basic_grants: got %0d exp 8", n_gnt); end
    for (int k = 0; k < 8 && k < addrs.size(); k++) begin
      checks++; if (addrs[k] !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL basic_addr[%0d]: got %h exp %h", k, addrs[k], 32'h100 + 32'(4 * k)); end
    end
    checks++; if (pops.size() != 8) begin errors++; $display("FAIL basic_count: got %0d exp 8", pops.size()); end
    for (int k = 0; k < 8 && k < pops.size(); k++) begin
      checks++; if (pops[k] !== 32'(k)) begin errors++; $display("FAIL basic_data[%0d]: got %h exp %h", k, pops[k], k); end
    end
    checks++; if (last_gnt_cyc - first_gnt_cyc != 7) begin errors++; $display("FAIL basic_req_rate: got span %0d exp 7", last_gnt_cyc - first_gnt_cyc); end
    checks++; if (last_pop_cyc - first_pop_cyc != 7) begin errors++; $display("FAIL basic_out_rate: got span %0d exp 7", last_pop_cyc - first_pop_cyc); end
    // start accepted on edge e: grant on e+1, response pushed on e+2, valid seen after it
    checks++; if (first_valid_cyc != start_cyc + 3) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", first_valid_cyc, start_cyc + 3); end
    checks++; if (done_cyc != last_pop_cyc + 1) begin errors++; $display("FAIL basic_done_time: got %0d exp %0d", done_cyc, last_pop_cyc + 1); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d exp 1", n_done); end
  endtask

  task automatic test_backpressure();
    reset_stats(); out_ready_i = 0; rand_gnt = 0;
    start_burst(32'h2000, 4, 16);
    repeat (20) @(posedge clk_i);
    #1;
    checks++; if (n_gnt != DEPTH) begin errors++; $display("FAIL bp_grants_held: got %0d exp %0d", n_gnt, DEPTH); end
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h0) begin errors++; $display("FAIL bp_head: got v%b %h exp v1 0", out_valid_o, out_data_o); end
    out_ready_i = 1;
    wait_done(200);
    checks++; if (max_out != DEPTH) begin errors++; $display("FAIL bp_max_out: got %0d exp %0d", max_out, DEPTH); end
    checks++; if (pops.size() != 16) begin errors++; $display("FAIL bp_count: got %0d exp 16", pops.size()); end
    for (int k = 0; k < pops.size(); k++) begin
      checks++; if (pops[k] !== 32'(k)) begin errors++; $display("FAIL bp_data[%0d]: got %h exp %h", k, pops[k], k); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d exp 0 violations", stab_err); end
`ifdef TCDM_BURST_READER_PERF_EN
    checks++; if (bp_cnt_o !== 32'(n_bp)) begin errors++; $display("FAIL bp_perf: got %0d exp %0d", bp_cnt_o, n_bp); end
`endif
  endtask

  task automatic test_stalls();
    reset_stats(); out_ready_i = 1; rand_gnt = 1;
    start_burst(32'h40, 12, 32);
    wait_done(1000);
    rand_gnt = 0;
    checks++; if (n_gnt != 32) begin errors++; $display("FAIL stall_grants: got %0d exp 32", n_gnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable: got %0d exp 0 violations", stab_err); end
    checks++; if (n_stall == 0) begin errors++; $display("FAIL stall_seen: got %0d exp >0", n_stall); end
    checks++; if (pops.size() != 32) begin errors++; $display("FAIL stall_count: got %0d exp 32", pops.size()); end
    for (int k = 0; k < pops.size(); k++) begin
      checks++; if (pops[k] !== 32'(3 * k)) begin errors++; $display("FAIL stall_data[%0d]: got %h exp %h", k, pops[k], 3 * k); end
    end
`ifdef TCDM_BURST_READER_PERF_EN
    checks++; if (stall_cnt_o !== 32'(n_stall)) begin errors++; $display("FAIL stall_perf: got %0d exp %0d", stall_cnt_o, n_stall); end
`endif
  endtask

  task automatic test_zero_len();
    reset_stats();
    start_burst(32'h0, 4, 0);
    wait_done(10);
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (n_req != 0) begin errors++; $display("FAIL zero_req: got %0d exp 0", n_req); end
    checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("FAIL zero_done_time: got %0d exp %0d", done_cyc, start_cyc + 1); end
    checks++; if (n_busy != 1) begin errors++; $display("FAIL zero_busy: got %0d exp 1", n_busy); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d exp 1", n_done); end
  endtask

  task automatic test_wrap_ignore();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    reset_stats(); out_ready_i = 1;
    start_burst(32'hFFFF_FFF8, 4, 4);
    @(posedge clk_i); #1;
    base_addr_i = 32'h5000; nb_words_i = 7; start_i = 1;
    @(posedge clk_i); #1 start_i = 0;
    wait_done(50);
    repeat (10) @(posedge clk_i);
    #1;
    checks++; if (n_gnt != 4 || addrs.size() != 4) begin errors++; $display("FAIL wrap_grants: got %0d exp 4", n_gnt); end
    for (int k = 0; k < 4 && k < addrs.size(); k++) begin
      checks++; if (addrs[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h exp %h", k, addrs[k], exp_a[k]); end
    end
    for (int k = 0; k < pops.size(); k++) begin
      checks++; if (pops[k] !== 32'(k)) begin errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", k, pops[k], k); end
    end
    checks++; if (n_done != 1 || busy_o !== 1'b0) begin errors++; $display("FAIL wrap_ignore: got done %0d busy %b exp 1 0", n_done, busy_o); end
  endtask

  task automatic test_clear();
    bit hit = 0;
    reset_stats(); out_ready_i = 1;
    start_burst(32'h300, 4, 10);
    for (int i = 0; i < 50 && !hit; i++) begin
      hit = n_gnt >= 3;
      if (!hit) begin @(posedge clk_i); #1; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL clr_wait: got %0d grants exp 3", n_gnt); end
    clear_i = 1;
    @(posedge clk_i); #1 clear_i = 0;
    @(negedge clk_i);
    checks++; if (tcdm_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
      begin errors++; $display("FAIL clr_ctrl: got req %b busy %b done %b exp 000", tcdm_req_o, busy_o, done_o); end
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || tcdm_add_o !== 32'h0)
      begin errors++; $display("FAIL clr_outs: got v%b d%h a%h exp v0 d0 a0", out_valid_o, out_data_o, tcdm_add_o); end
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL clr_late_drop: got %b exp 0", out_valid_o); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL clr_no_done: got %0d exp 0", n_done); end
    reset_stats();
    start_burst(32'h400, 8, 5);
    wait_done(100);
    checks++; if (n_gnt != 5 || pops.size() != 5) begin errors++; $display("FAIL clr_rerun_cnt: got %0d/%0d exp 5/5", n_gnt, pops.size()); end
    for (int k = 0; k < pops.size(); k++) begin
      checks++; if (pops[k] !== 32'(2 * k)) begin errors++; $display("FAIL clr_rerun_data[%0d]: got %h exp %h", k, pops[k], 2 * k); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stalls();
    test_zero_len();
    test_wrap_ignore();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
